// File: rtl/ram_bus_pkg.sv
// Shared constants and FSM encoding for the nibble RAM bus initiator.
package ram_bus_pkg;

  localparam int AW     = 12;
  localparam int DW     = 4;
  localparam int ACC_CW = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_SETUP   = 2'd1;
  localparam state_t ST_ACCESS  = 2'd2;
  localparam state_t ST_RECOVER = 2'd3;

endpackage

// File: rtl/ram_bus_master_if.sv
// Core-side request/response handshake plus the RAM strobes; the shared data
// bus stays a plain inout on the master so the tristate lives in one place.
interface ram_bus_master_if;
  import ram_bus_pkg::*;

  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_len;

  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_last;
  logic          busy;

  logic [AW-1:0] mem_addr;
  logic          mem_cs;
  logic          mem_we;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_len,
    output req_ready, rsp_valid, rsp_rdata, rsp_last, busy,
    output mem_addr, mem_cs, mem_we
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_len,
    input  req_ready, rsp_valid, rsp_rdata, rsp_last, busy,
    input  mem_addr, mem_cs, mem_we
  );

endinterface

// File: rtl/ram_addr_counter.sv
// Loadable up-counter for the beat address; wraps modulo 2^AW, one-cycle update,
// load takes priority over increment.
module ram_addr_counter #(
  parameter int AW = ram_bus_pkg::AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  input  logic          en,
  output logic [AW-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + AW'(1);
    end
  end

endmodule

// File: rtl/ram_bus_master.sv
// RAM bus initiator: SETUP/ACCESS/RECOVER per beat, ACCESS_CYC+2 cycles per beat,
// req_ready only in IDLE; read data returned without backpressure.
module ram_bus_master #(
  parameter int AW         = ram_bus_pkg::AW,
  parameter int DW         = ram_bus_pkg::DW,
  parameter int ACCESS_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  ram_bus_master_if.master bus,
  inout  wire  [DW-1:0]    mem_data
);
  import ram_bus_pkg::*;

  localparam logic [ACC_CW-1:0] ACC_LOAD = ACC_CW'(ACCESS_CYC - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ACC_CW-1:0] acc_cnt;
  logic [ACC_CW-1:0] acc_nxt;
  logic [3:0]        beat_cnt;
  logic [3:0]        beat_nxt;
  logic              wr_q;
  logic              wr_nxt;
  logic [DW-1:0]     wdata_q;
  logic              mem_oe;
  logic              cs_q;
  logic              we_q;
  logic              busy_q;
  logic              ready_q;
  logic              rsp_valid_q;
  logic              rsp_last_q;
  logic [DW-1:0]     rsp_rdata_q;
  logic [AW-1:0]     addr_q;
  logic              accept;
  logic              addr_step;
  logic              capture;

  assign accept  = (state == ST_IDLE) && bus.req_valid;
  assign capture = (state == ST_ACCESS) && (acc_cnt == '0) && !wr_q;
  assign wr_nxt  = accept ? bus.req_write : wr_q;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc_cnt;
    beat_nxt  = beat_cnt;
    addr_step = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_nxt = ST_SETUP;
          beat_nxt  = bus.req_len;
        end
      end
      ST_SETUP: begin
        state_nxt = ST_ACCESS;
        acc_nxt   = ACC_LOAD;
      end
      ST_ACCESS: begin
        if (acc_cnt == '0) begin
          state_nxt = ST_RECOVER;
        end else begin
          acc_nxt = acc_cnt - 1'b1;
        end
      end
      ST_RECOVER: begin
        if (beat_cnt != 4'd0) begin
          state_nxt = ST_SETUP;
          beat_nxt  = beat_cnt - 1'b1;
          addr_step = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Strobes are computed from the next state so every bus output is a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      acc_cnt     <= '0;
      beat_cnt    <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      mem_oe      <= 1'b0;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state    <= state_nxt;
      acc_cnt  <= acc_nxt;
      beat_cnt <= beat_nxt;
      if (accept) begin
        wr_q    <= bus.req_write;
        wdata_q <= bus.req_wdata;
      end
      cs_q        <= (state_nxt == ST_ACCESS);
      we_q        <= (state_nxt == ST_ACCESS) && wr_nxt;
      mem_oe      <= (state_nxt != ST_IDLE) && wr_nxt;
      busy_q      <= (state_nxt != ST_IDLE);
      ready_q     <= (state_nxt == ST_IDLE);
      rsp_valid_q <= capture;
      rsp_last_q  <= capture && (beat_cnt == 4'd0);
      if (capture) begin
        rsp_rdata_q <= mem_data;
      end
    end
  end

  ram_addr_counter #(
    .AW (AW)
  ) u_addr_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (bus.req_addr),
    .en       (addr_step),
    .count    (addr_q)
  );

  // The RAM only drives while cs & ~we, which never coincides with mem_oe.
  assign mem_data = mem_oe ? wdata_q : {DW{1'bz}};

  assign bus.mem_addr  = addr_q;
  assign bus.mem_cs    = cs_q;
  assign bus.mem_we    = we_q;
  assign bus.busy      = busy_q;
  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule
